instruction_sequencer: RTL and testbench

- Synthesizable instruction feeder that replaces the behavioural program-memory driver in front of `core`.
- Holds a loadable program RAM and issues one instruction per accepted start/busy handshake.
- Follows core branch redirects, supports single-step mode, drains in-flight work and reports cycle and retired-instruction counts.
- Sits between the host/loader and `core`.

---
 rtl/instruction_sequencer_pkg.sv | 21 ++
 rtl/instruction_sequencer_program_memory.sv | 38 +++
 rtl/instruction_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_pkg
//   Shared definitions for the instruction sequencer slice.
//   - SEQ_INSTR_WIDTH : default instruction width. It must match the core's
//                       instruction width.
//   - seq_state_e     : sequencer FSM states. The encoding is fixed at
//                       IDLE=0, RUN=1, DRAIN=2, DONE=3 so that debug tools
//                       can decode the state.
// -----------------------------------------------------------------------------
package instruction_sequencer_pkg;

    localparam int SEQ_INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_program_memory.sv
// -----------------------------------------------------------------------------
// program_memory
//   Program store for the instruction sequencer. It holds DEPTH words of
//   INSTR_WIDTH bits. Writes are synchronous. Reads are asynchronous, so the
//   word at raddr appears in the same cycle. The contents are not reset.
//
//   Ports:
//     clk    in   write clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  word at raddr (combinational)
// -----------------------------------------------------------------------------
module program_memory #(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//   Feeds instructions from a loadable program RAM to the core. It issues one
//   instruction for each accepted start/busy handshake. It also follows core
//   branch redirects, supports single-step mode, drains in-flight work at the
//   end of a program, and counts active cycles and retired instructions.
//
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     loadEn/loadAddr/Data  program write port (honoured only in IDLE/DONE)
//     programLength         number of instructions, sampled on run
//     run                   start-program pulse
//     stepMode, step        single-step control
//     busy                  core cannot accept this cycle
//     branchValid/Target    core redirect
//     instructionOut        mem[pc]
//     start                 issue request (combinational on busy)
//     pc                    current fetch PC
//     running, done         status flags
//     loadError             sticky flag: a load was attempted while running
//     cycleCount            number of cycles spent in RUN and DRAIN
//     retiredCount          number of accepted instructions
// -----------------------------------------------------------------------------
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = SEQ_INSTR_WIDTH,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadEn,
    input  logic [ADDR_WIDTH-1:0]  loadAddr,
    input  logic [INSTR_WIDTH-1:0] loadData,
    input  logic [ADDR_WIDTH:0]    programLength,
    input  logic                   run,
    input  logic                   stepMode,
    input  logic                   step,
    input  logic                   busy,
    input  logic                   branchValid,
    input  logic [ADDR_WIDTH:0]    branchTarget,
    output logic [INSTR_WIDTH-1:0] instructionOut,
    output logic                   start,
    output logic [ADDR_WIDTH:0]    pc,
    output logic                   running,
    output logic                   done,
    output logic                   loadError,
    output logic [CNT_WIDTH-1:0]   cycleCount,
    output logic [CNT_WIDTH-1:0]   retiredCount
);

    localparam logic [ADDR_WIDTH:0] DEPTH_PC = (ADDR_WIDTH+1)'(DEPTH);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   pc_q, pc_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  load_err_q, load_err_d;
    logic                  step_pend_q, step_pend_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;

    logic                  idle_or_done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [ADDR_WIDTH:0]   pc_next_run;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign mem_we       = loadEn && idle_or_done;

    // A redirect may park pc beyond the memory. In that case pc >= len, so
    // the word read is not used, and the read address is held at 0.
    assign mem_raddr = (pc_q < DEPTH_PC) ? pc_q[ADDR_WIDTH-1:0] : '0;

    program_memory #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_program_memory (
        .clk   (clk),
        .we    (mem_we),
        .waddr (loadAddr),
        .wdata (loadData),
        .raddr (mem_raddr),
        .rdata (instructionOut)
    );

    // start is also the accept condition, because start already includes
    // !busy.
    assign start = (state_q == ST_RUN) && !busy && (pc_q < len_q)
                   && (!stepMode || step_pend_q);

    // A redirect takes priority over the post-accept increment.
    assign pc_next_run = branchValid ? branchTarget
                       : (start ? pc_q + (ADDR_WIDTH+1)'(1) : pc_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        cycle_d     = cycle_q;
        retired_d   = retired_q;
        load_err_d  = load_err_q;
        step_pend_d = step_pend_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run) begin
                    len_d       = programLength;
                    pc_d        = '0;
                    cycle_d     = '0;
                    retired_d   = '0;
                    load_err_d  = 1'b0;
                    step_pend_d = 1'b0;
                    state_d     = (programLength == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + CNT_WIDTH'(1);
                if (start) begin
                    retired_d   = retired_q + CNT_WIDTH'(1);
                    step_pend_d = 1'b0;
                end else if (step) begin
                    // A step that arrives while one is already pending is
                    // dropped, because there is no queue.
                    step_pend_d = 1'b1;
                end
                if (loadEn) begin
                    load_err_d = 1'b1;
                end
                pc_d    = pc_next_run;
                state_d = (pc_next_run >= len_q) ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                cycle_d = cycle_q + CNT_WIDTH'(1);
                if (loadEn) begin
                    load_err_d = 1'b1;
                end
                if (branchValid) begin
                    pc_d    = branchTarget;
                    state_d = (branchTarget < len_q) ? ST_RUN : ST_DRAIN;
                end else if (!busy) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            cycle_q     <= '0;
            retired_q   <= '0;
            load_err_q  <= 1'b0;
            step_pend_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
            load_err_q  <= load_err_d;
            step_pend_q <= step_pend_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign pc           = pc_q;
    assign running      = running_q;
    assign done         = done_q;
    assign loadError    = load_err_q;
    assign cycleCount   = cycle_q;
    assign retiredCount = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//   Directed scenarios followed by randomized programs. Every cycle the bench
//   compares all DUT outputs against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

    localparam int IW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [IW-1:0] loadData;
    logic [AW:0]   programLength;
    logic          run;
    logic          stepMode;
    logic          step;
    logic          busy;
    logic          branchValid;
    logic [AW:0]   branchTarget;
    logic [IW-1:0] instructionOut;
    logic          start;
    logic [AW:0]   pc;
    logic          running;
    logic          done;
    logic          loadError;
    logic [CW-1:0] cycleCount;
    logic [CW-1:0] retiredCount;

    instruction_sequencer #(
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .loadEn         (loadEn),
        .loadAddr       (loadAddr),
        .loadData       (loadData),
        .programLength  (programLength),
        .run            (run),
        .stepMode       (stepMode),
        .step           (step),
        .busy           (busy),
        .branchValid    (branchValid),
        .branchTarget   (branchTarget),
        .instructionOut (instructionOut),
        .start          (start),
        .pc             (pc),
        .running        (running),
        .done           (done),
        .loadError      (loadError),
        .cycleCount     (cycleCount),
        .retiredCount   (retiredCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model. "active" covers both issuing and draining; the
    // model treats pc >= len as draining.
    logic [IW-1:0] m_mem [DEPTH];
    int            m_pc, m_len;
    bit            m_active, m_finished, m_pend, m_err;
    logic [CW-1:0] m_cycles, m_retired;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_start();
        return m_active && (m_pc < m_len) && !busy && (!stepMode || m_pend);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_len = 0; m_active = 0; m_finished = 0;
        m_pend = 0; m_err = 0; m_cycles = '0; m_retired = '0;
    endtask

    task automatic check_outputs();
        chk("start", start, exp_start());
        chk("pc", pc, m_pc);
        chk("running", running, m_active);
        chk("done", done, m_finished);
        chk("loadError", loadError, m_err);
        chk("cycleCount", cycleCount, m_cycles);
        chk("retiredCount", retiredCount, m_retired);
        if (m_active && m_pc < m_len)
            chk("instructionOut", instructionOut, m_mem[m_pc]);
    endtask

    // Apply one clock edge to the model, using the inputs of this cycle.
    task automatic model_edge();
        bit acc;
        acc = exp_start();
        if (m_active) begin
            m_cycles++;
            if (acc) begin
                m_retired++;
                m_pend = 0;
                $display("issue pc=%0d instr=%08h retired=%0d", m_pc, m_mem[m_pc], m_retired);
            end else if (m_pc < m_len && step) begin
                m_pend = 1;
            end
            if (loadEn) m_err = 1;
            if (m_pc >= m_len && !branchValid && !busy) begin
                m_active = 0;
                m_finished = 1;
            end
            if (branchValid) m_pc = int'(branchTarget);
            else if (acc) m_pc++;
        end else begin
            if (loadEn) m_mem[loadAddr] = loadData;
            if (run) begin
                m_len = int'(programLength);
                m_pc = 0; m_cycles = '0; m_retired = '0; m_err = 0; m_pend = 0;
                m_active = (m_len != 0);
                m_finished = (m_len == 0);
            end
        end
    endtask

    // Inputs are driven at posedge+1. Outputs are checked on the negedge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        loadEn = 1'b1; loadAddr = AW'(addr); loadData = data;
        tick();
        loadEn = 1'b0;
    endtask

    task automatic start_prog(input int len);
        programLength = (AW+1)'(len); run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", done, 1'b1);
    endtask

    initial begin
        int n;
        int len;
        logic [IW-1:0] word;

        reset = 1'b1; loadEn = 0; loadAddr = '0; loadData = '0; programLength = '0;
        run = 0; stepMode = 0; step = 0; busy = 0; branchValid = 0; branchTarget = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        for (int a = 0; a < DEPTH; a++) load_word(a, $urandom);

        // Straight-line program of four instructions with the core never busy.
        load_word(0, 32'h11); load_word(1, 32'h22); load_word(2, 32'h33); load_word(3, 32'h44);
        start_prog(4);
        chk("t1_first_instr", instructionOut, 32'h11);
        run_to_done(50, n);
        chk("t1_latency", n, 5);
        chk("t1_cycles", cycleCount, 5);
        chk("t1_retired", retiredCount, 4);

        // The core stays busy for 3 cycles after the second accept.
        start_prog(4);
        tick(); tick();
        busy = 1'b1;
        tick(); tick(); tick();
        chk("t2_pc_held", pc, 2);
        busy = 1'b0;
        run_to_done(50, n);
        chk("t2_cycles", cycleCount, 8);
        chk("t2_retired", retiredCount, 4);

        // A redirect that coincides with the accept at pc=5.
        for (int a = 0; a < 8; a++) load_word(a, $urandom);
        start_prog(8);
        repeat (5) tick();
        branchValid = 1'b1; branchTarget = 9'd2;
        tick();
        branchValid = 1'b0;
        chk("t3_pc_redirect", pc, 2);
        chk("t3_retired", retiredCount, 6);
        run_to_done(50, n);

        // A redirect while draining returns the block to RUN.
        start_prog(4);
        repeat (4) tick();
        busy = 1'b1;
        tick(); tick();
        chk("t4_draining", running, 1'b1);
        busy = 1'b0; branchValid = 1'b1; branchTarget = 9'd1;
        tick();
        branchValid = 1'b0;
        chk("t4_pc", pc, 1);
        chk("t4_running", running, 1'b1);
        run_to_done(50, n);
        chk("t4_retired", retiredCount, 7);

        // Single-step mode.
        stepMode = 1'b1;
        start_prog(3);
        tick(); tick(); tick();
        chk("t5_no_step_no_start", start, 1'b0);
        busy = 1'b1;
        step = 1'b1; tick();
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0; busy = 1'b0;
        tick(); tick(); tick();
        chk("t5_one_issue", retiredCount, 1);
        repeat (2) begin
            step = 1'b1; tick();
            step = 1'b0; tick(); tick();
        end
        chk("t5_retired", retiredCount, 3);
        run_to_done(50, n);
        stepMode = 1'b0;

        // A load during RUN is dropped and sets loadError.
        start_prog(4);
        tick();
        word = ~m_mem[3];
        loadEn = 1'b1; loadAddr = 8'd3; loadData = word;
        tick();
        loadEn = 1'b0;
        chk("t6_loadError", loadError, 1'b1);
        run_to_done(50, n);
        chk("t6_loadError_sticky", loadError, 1'b1);

        // An asynchronous reset in the middle of a run.
        start_prog(6);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("t7_rst_pc", pc, 0);
        chk("t7_rst_start", start, 1'b0);
        chk("t7_rst_running", running, 1'b0);
        chk("t7_rst_done", done, 1'b0);
        chk("t7_rst_cycles", cycleCount, 0);
        chk("t7_rst_retired", retiredCount, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        tick(); tick();
        start_prog(0);
        chk("t7_len0_done", done, 1'b1);
        chk("t7_len0_cycles", cycleCount, 0);
        tick();

        // Randomized programs.
        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(1, 12);
            for (int k = 0; k < 3; k++) load_word($urandom_range(0, 15), $urandom);
            stepMode = ($urandom % 2) == 1;
            start_prog(len);
            n = 0;
            while (done !== 1'b1 && n < 400) begin
                busy = ($urandom % 3) == 0;
                step = ($urandom % 3) == 0;
                branchValid = (n < 100) && (($urandom % 16) == 0);
                branchTarget = (AW+1)'($urandom_range(0, len + 1));
                loadEn = ($urandom % 20) == 0;
                loadAddr = AW'($urandom_range(0, 15));
                loadData = $urandom;
                tick();
                n++;
            end
            busy = 0; step = 0; branchValid = 0; loadEn = 0;
            chk("rand_done", done, 1'b1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
